// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundle between the hazard controller and the datapath.
//   Hazard sources, driven by the datapath:
//     ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, memread_ID_EX,
//     Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX
//   Pipeline control, driven by the controller:
//     pc_en, enable_*/flush_* for each pipeline register, halted
//     stall_cnt, present only when PIPE_PERF_CNT_EN is defined
// Modports: master = controller side, slave = datapath side.
// Optional feature macro: PIPE_PERF_CNT_EN
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic       ihit;
  logic       dhit;
  logic       dREN_EX_MEM;
  logic       dWEN_EX_MEM;
  logic       halt_EX_MEM;
  logic       memread_ID_EX;
  logic [4:0] Rt_ID_EX;
  logic [4:0] Rs_IF_ID;
  logic [4:0] Rt_IF_ID;
  logic       branch_taken_EX;

  logic pc_en;
  logic enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  // A zero-width counter would not elaborate; reject it early.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  modport master (
    input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, memread_ID_EX,
    input  Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX,
    output pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
    output flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    output halted
`ifdef PIPE_PERF_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, memread_ID_EX,
    output Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX,
    input  pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
    input  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    input  halted
`ifdef PIPE_PERF_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central sequencer for the 5-stage pipeline. Produces the PC write
// enable and the enable/flush pair of every pipeline register from cache handshakes,
// load-use hazards, taken branches and halt. Outputs are combinational from state and
// inputs; only the state (and optional stall counter) is registered.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   hz   pipeline_hazard_ctrl_if.master (hazard inputs in, pipeline controls out)
// Optional feature macro: PIPE_PERF_CNT_EN adds hz.stall_cnt, a wrapping count of cycles
// with pc_en=0 while running or data-stalled.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  pipeline_hazard_ctrl_if.master        hz
);

  typedef enum logic [1:0] {StInit, StRun, StDstall, StHalted} state_e;

  state_e state_q, state_d;

  logic mem_busy;
  logic load_use;

  logic pc_en;
  logic en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb;
  logic halted;

  assign mem_busy = (hz.dREN_EX_MEM | hz.dWEN_EX_MEM) & ~hz.dhit;
  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = hz.memread_ID_EX && (hz.Rt_ID_EX != 5'd0) &&
                    ((hz.Rt_ID_EX == hz.Rs_IF_ID) || (hz.Rt_ID_EX == hz.Rt_IF_ID));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    en_if_id  = 1'b1;
    en_id_ex  = 1'b1;
    en_ex_mem = 1'b1;
    en_mem_wb = 1'b1;
    fl_if_id  = 1'b0;
    fl_id_ex  = 1'b0;
    fl_ex_mem = 1'b0;
    fl_mem_wb = 1'b0;
    halted    = 1'b0;

    case (state_q)
      StInit: begin
        pc_en     = 1'b0;
        en_if_id  = 1'b0;
        en_id_ex  = 1'b0;
        en_ex_mem = 1'b0;
        en_mem_wb = 1'b0;
        fl_if_id  = 1'b1;
        fl_id_ex  = 1'b1;
        fl_ex_mem = 1'b1;
        fl_mem_wb = 1'b1;
        state_d   = StRun;
      end

      StRun, StDstall: begin
        if ((state_q == StRun) && hz.halt_EX_MEM) begin
          // Let older instructions retire through WB, squash everything younger.
          pc_en     = 1'b0;
          fl_if_id  = 1'b1;
          fl_id_ex  = 1'b1;
          fl_ex_mem = 1'b1;
          state_d   = StHalted;
        end else if (((state_q == StRun) && mem_busy) ||
                     ((state_q == StDstall) && !hz.dhit)) begin
          // Freeze everything up to EX/MEM, bubble into WB.
          pc_en     = 1'b0;
          en_if_id  = 1'b0;
          en_id_ex  = 1'b0;
          en_ex_mem = 1'b0;
          fl_mem_wb = 1'b1;
          state_d   = StDstall;
        end else begin
          state_d = StRun;
          if (hz.branch_taken_EX) begin
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            en_if_id = 1'b0;
            fl_id_ex = 1'b1;
          end else if (!hz.ihit) begin
            pc_en    = 1'b0;
            fl_if_id = 1'b1;
          end
        end
      end

      StHalted: begin
        pc_en     = 1'b0;
        en_if_id  = 1'b0;
        en_id_ex  = 1'b0;
        en_ex_mem = 1'b0;
        en_mem_wb = 1'b0;
        halted    = 1'b1;
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign hz.pc_en         = pc_en;
  assign hz.enable_IF_ID  = en_if_id;
  assign hz.enable_ID_EX  = en_id_ex;
  assign hz.enable_EX_MEM = en_ex_mem;
  assign hz.enable_MEM_WB = en_mem_wb;
  assign hz.flush_IF_ID   = fl_if_id;
  assign hz.flush_ID_EX   = fl_id_ex;
  assign hz.flush_EX_MEM  = fl_ex_mem;
  assign hz.flush_MEM_WB  = fl_mem_wb;
  assign hz.halted        = halted;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_cnt_en;

  assign stall_cnt_en = ~pc_en & ((state_q == StRun) | (state_q == StDstall));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_en) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the stimulus process drives inputs shortly
// after each rising edge, predicts the outputs from a rule-based model and queues them;
// the monitor samples on the falling edge and compares against the queue head.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 32;

  typedef struct {
    string       name;
    logic [9:0]  outs;   // {pc_en, en IF/ID,ID/EX,EX/MEM,MEM/WB, fl same order, halted}
    logic [31:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pipeline_hazard_ctrl_if #(.CNT_W(CntW)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CntW)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model: "has the core started", "is it waiting on data memory", "is it halted".
  bit          m_started  = 1'b0;
  bit          m_mem_wait = 1'b0;
  bit          m_halted   = 1'b0;
  logic [31:0] m_stalls   = '0;

  function automatic logic [9:0] predict();
    bit mem_req, hazard;
    mem_req = (hz.dREN_EX_MEM || hz.dWEN_EX_MEM) && !hz.dhit;
    hazard  = hz.memread_ID_EX && hz.Rt_ID_EX != 0 &&
              (hz.Rt_ID_EX == hz.Rs_IF_ID || hz.Rt_ID_EX == hz.Rt_IF_ID);
    if (RST || !m_started)                  return {1'b0, 4'b0000, 4'b1111, 1'b0};
    if (m_halted)                           return {1'b0, 4'b0000, 4'b0000, 1'b1};
    if (!m_mem_wait && hz.halt_EX_MEM)      return {1'b0, 4'b1111, 4'b1110, 1'b0};
    if (m_mem_wait ? !hz.dhit : mem_req)    return {1'b0, 4'b0001, 4'b0001, 1'b0};
    if (hz.branch_taken_EX)                 return {1'b1, 4'b1111, 4'b1100, 1'b0};
    if (hazard)                             return {1'b0, 4'b0111, 4'b0100, 1'b0};
    if (!hz.ihit)                           return {1'b0, 4'b1111, 4'b1000, 1'b0};
    return {1'b1, 4'b1111, 4'b0000, 1'b0};
  endfunction

  // One cycle: predict with current inputs, wait for the edge, advance the model.
  task automatic step(input string nm);
    exp_t       e;
    logic [9:0] o;
    bit         mem_req;
    o      = predict();
    e.name = nm;
    e.outs = o;
    e.cnt  = RST ? 32'd0 : m_stalls;
    exp_q.push_back(e);
    mem_req = (hz.dREN_EX_MEM || hz.dWEN_EX_MEM) && !hz.dhit;
    @(posedge CLK);
    if (RST) begin
      m_started  = 1'b0;
      m_mem_wait = 1'b0;
      m_halted   = 1'b0;
      m_stalls   = '0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_halted) begin
      if (!o[9]) m_stalls = m_stalls + 32'd1;
      if (!m_mem_wait && hz.halt_EX_MEM) m_halted = 1'b1;
      else m_mem_wait = m_mem_wait ? !hz.dhit : mem_req;
    end
    #1;
  endtask

  task automatic clear_inputs();
    hz.ihit            = 1'b1;
    hz.dhit            = 1'b0;
    hz.dREN_EX_MEM     = 1'b0;
    hz.dWEN_EX_MEM     = 1'b0;
    hz.halt_EX_MEM     = 1'b0;
    hz.memread_ID_EX   = 1'b0;
    hz.Rt_ID_EX        = 5'd0;
    hz.Rs_IF_ID        = 5'd0;
    hz.Rt_IF_ID        = 5'd0;
    hz.branch_taken_EX = 1'b0;
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [9:0] got;
      e   = exp_q.pop_front();
      got = {hz.pc_en, hz.enable_IF_ID, hz.enable_ID_EX, hz.enable_EX_MEM, hz.enable_MEM_WB,
             hz.flush_IF_ID, hz.flush_ID_EX, hz.flush_EX_MEM, hz.flush_MEM_WB, hz.halted};
      checks++;
      if (got !== e.outs) begin
        errors++;
        $display("FAIL %s: pc_en/en/fl/halted got %b expected %b", e.name, got, e.outs);
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (hz.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, hz.stall_cnt, e.cnt);
      end
`endif
    end
  end

  initial begin
    clear_inputs();
    @(posedge CLK);
    #1;
    step("reset_hold");
    step("reset_hold");
    RST = 1'b0;
    step("init_cycle");
    step("first_run");

    // Data stall: three miss cycles, then completion.
    hz.dREN_EX_MEM = 1'b1;
    repeat (3) step("dstall");
    hz.dhit = 1'b1;
    step("dstall_done");
    clear_inputs();

    // Load-use, then the same with the load targeting r0.
    hz.memread_ID_EX = 1'b1;
    hz.Rt_ID_EX      = 5'd5;
    hz.Rs_IF_ID      = 5'd5;
    step("load_use");
    hz.Rt_ID_EX = 5'd0;
    hz.Rs_IF_ID = 5'd0;
    step("load_use_r0");
    clear_inputs();

    // Branch alone, then branch together with a store miss.
    hz.branch_taken_EX = 1'b1;
    step("branch");
    hz.dWEN_EX_MEM = 1'b1;
    step("branch_vs_dstall");
    hz.dhit = 1'b1;
    step("branch_after_dhit");
    clear_inputs();

    // Instruction miss for two cycles.
    hz.ihit = 1'b0;
    repeat (2) step("imiss");
    clear_inputs();

    // Halt, then stay halted through ihit toggling until reset mid-cycle.
    hz.halt_EX_MEM = 1'b1;
    step("halt_retire");
    hz.halt_EX_MEM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hz.ihit = i[0];
      step("halted");
    end
    #3;
    RST = 1'b1;
    step("reset_from_halt");
    RST = 1'b0;
    clear_inputs();
    step("init_after_halt");

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 3000; i++) begin
      RST                = ($urandom_range(0, 59) == 0);
      hz.ihit            = ($urandom_range(0, 3) != 0);
      hz.dhit            = $urandom_range(0, 1) == 1;
      hz.dREN_EX_MEM     = ($urandom_range(0, 4) == 0);
      hz.dWEN_EX_MEM     = ($urandom_range(0, 4) == 0);
      hz.halt_EX_MEM     = ($urandom_range(0, 39) == 0);
      hz.memread_ID_EX   = ($urandom_range(0, 2) == 0);
      hz.Rt_ID_EX        = 5'($urandom_range(0, 3));
      hz.Rs_IF_ID        = 5'($urandom_range(0, 3));
      hz.Rt_IF_ID        = 5'($urandom_range(0, 3));
      hz.branch_taken_EX = ($urandom_range(0, 5) == 0);
      step("random");
    end
    RST = 1'b0;
    stim_done = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion, expected stimulus to finish");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline.
- Drives the enable/flush pair of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Decisions are based on cache handshakes, load-use hazards, taken branches/jumps and halt.
- Sits beside the datapath; it is the only source of the enable_*/flush_* signals consumed by the pipeline registers.

Parameters:
- CNT_W, 32, width of the stall counter (only used when PIPE_PERF_CNT_EN is defined).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction cache returned a valid instruction this cycle.
- dhit  in  1  data cache completed the access presented by EX/MEM this cycle.
- dREN_EX_MEM  in  1  EX/MEM holds a load.
- dWEN_EX_MEM  in  1  EX/MEM holds a store.
- halt_EX_MEM  in  1  EX/MEM holds a halt instruction.
- memread_ID_EX  in  1  ID/EX holds a load.
- Rt_ID_EX  in  5  destination register of the load in ID/EX.
- Rs_IF_ID  in  5  rs field of the instruction in IF/ID.
- Rt_IF_ID  in  5  rt field of the instruction in IF/ID.
- branch_taken_EX  in  1  branch/jump resolved taken in EX; PC mux selects target.
- pc_en  out  1  PC register write enable.
- enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  pipeline register load enables.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  pipeline register clears; a flush overrides the enable in the register.
- halted  out  1  processor halted (sticky).
- stall_cnt  out  CNT_W  stall cycle count (present only with PIPE_PERF_CNT_EN).

Behaviour:
- Registered FSM with states INIT, RUN, DSTALL, HALTED. All outputs are combinational from state and inputs (zero latency).
- RST is asynchronous and active-high. While RST=1 and in INIT:
  - all flush_*=1, all enable_*=0, pc_en=0, halted=0.
- INIT -> RUN unconditionally on the first clock edge after RST falls.
- RUN evaluates the following in priority order (first match wins):
  1. halt_EX_MEM=1: next state HALTED. This cycle: enable_MEM_WB=1 so older instructions retire; flush_IF_ID=flush_ID_EX=flush_EX_MEM=1; pc_en=0.
  2. (dREN_EX_MEM|dWEN_EX_MEM)=1 and dhit=0: next state DSTALL. This cycle: pc_en=0; enable_IF_ID/ID_EX/EX_MEM=0; flush_MEM_WB=1 (bubble into WB).
  3. branch_taken_EX=1: pc_en=1 (loads target, regardless of ihit); flush_IF_ID=flush_ID_EX=1; enable_EX_MEM=enable_MEM_WB=1.
  4. Load-use hazard, defined as memread_ID_EX=1, Rt_ID_EX!=0, and Rt_ID_EX matches Rs_IF_ID or Rt_IF_ID: pc_en=0; enable_IF_ID=0; flush_ID_EX=1; enable_EX_MEM=enable_MEM_WB=1.
  5. ihit=0: pc_en=0; flush_IF_ID=1; all other enables=1.
  6. Otherwise: pc_en=1, all enables=1, all flushes=0.
- DSTALL: outputs as in RUN case 2 while dhit=0.
  - When dhit=1, the same cycle evaluates RUN cases 3–6 with the memory operation complete; next state RUN.
  - A halt cannot occur in DSTALL: halt is not a memory op.
- HALTED: all enable_*=0, all flush_*=0 (contents frozen), pc_en=0, halted=1. Exit only by reset.
- Reset asserted mid-DSTALL or mid-HALTED: immediate return to INIT outputs; no pending access state is retained.
- Simultaneous dmem stall and branch_taken_EX: the dmem stall wins. The branch is held in ID/EX/EX stage and re-evaluated after dhit.
- Any output not listed for a case defaults to enable=1, flush=0, with pc_en as stated.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cnt port exists.
  - Counter resets to 0 and increments by 1 (wrapping at 2^CNT_W) every cycle in which pc_en=0 and state is RUN or DSTALL.
  - Holds in HALTED.
- PIPE_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert RST mid-clock -> all flush_*=1, enable_*=0, pc_en=0 immediately. Release RST -> one INIT cycle, then RUN with pc_en=1, all enables=1 given ihit=1.
- Data stall: dREN_EX_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> pc_en=0, flush_MEM_WB=1, upstream enables=0 for 3 cycles. The 4th cycle shows pc_en=1 and all enables=1; stall_cnt=3.
- Load-use: memread_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5 -> pc_en=0, enable_IF_ID=0, flush_ID_EX=1 for one cycle. Repeat with Rt_ID_EX=0 -> no stall.
- Branch vs stall priority: branch_taken_EX=1 alone -> flush_IF_ID=flush_ID_EX=1, pc_en=1. The same cycle with dWEN_EX_MEM=1, dhit=0 -> DSTALL outputs and no flush_IF_ID.
- Instruction miss: ihit=0 for 2 cycles -> pc_en=0, flush_IF_ID=1, enable_ID_EX/EX_MEM/MEM_WB=1 both cycles.
- Halt: halt_EX_MEM=1 -> one retire cycle (enable_MEM_WB=1), then halted=1 and all enables=0 indefinitely. A later ihit toggle causes no change; RST clears halted.
